// File: rtl/uart_tx_arbiter_if.sv
// Producer/transmitter bundle for uart_tx_arbiter.
// master = arbiter side, slave = producers plus transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ack;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 tx_busy;
    logic                 arb_busy;
    logic [3:0]           grant_id;
    logic                 err_timeout;

    modport master (
        input  req,
        input  req_data,
        input  tx_busy,
        output req_ack,
        output tx_data,
        output tx_start,
        output arb_busy,
        output grant_id,
        output err_timeout
    );

    modport slave (
        output req,
        output req_data,
        output tx_busy,
        input  req_ack,
        input  tx_data,
        input  tx_start,
        input  arb_busy,
        input  grant_id,
        input  err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ producers.
// Define UART_ARB_TAG_EN to prefix every data byte with a tag {4'hA, grant_id}.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_arbiter_if.master    bus
);

    localparam int CW = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_BUSY = 3'd1;
    localparam logic [2:0] S_WAIT_DONE = 3'd2;
`ifdef UART_ARB_TAG_EN
    localparam logic [2:0] S_TAG_BUSY  = 3'd3;
    localparam logic [2:0] S_TAG_DONE  = 3'd4;
    localparam logic [2:0] S_TAG_GAP   = 3'd5;
`endif

    logic [2:0]         state_q, state_d;
    logic [3:0]         rr_q, rr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [3:0]         grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               start_q, start_d;
    logic               err_q, err_d;
`ifdef UART_ARB_TAG_EN
    logic [7:0]         byte_q, byte_d;
`endif

    logic [NUM_REQ-1:0] hi_mask;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] ack_vec;
    logic               found;
    logic [3:0]         sel;
    logic [3:0]         rr_nxt;
    logic [7:0]         sel_byte;

    // Round-robin pick: lowest request at or above rr_q, else lowest overall.
    always_comb begin
        hi_mask = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            hi_mask[k] = (4'(k) >= rr_q);
        end
        masked = bus.req & hi_mask;
        pick   = (|masked) ? masked : bus.req;
        found  = |bus.req;
        sel    = 4'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (pick[k]) begin
                sel = 4'(k);
            end
        end
        rr_nxt = (sel == 4'(NUM_REQ - 1)) ? 4'd0 : sel + 4'd1;
    end

    // Byte and one-hot acknowledge for the selected requester.
    always_comb begin
        sel_byte = 8'h00;
        ack_vec  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel == 4'(k)) begin
                sel_byte   = bus.req_data[8*k +: 8];
                ack_vec[k] = 1'b1;
            end
        end
    end

    // Next-state logic: grant, wait for busy to rise, wait for frame end.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        ack_d     = '0;
        start_d   = 1'b0;
        err_d     = 1'b0;
`ifdef UART_ARB_TAG_EN
        byte_d    = byte_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = sel;
                    ack_d   = ack_vec;
                    start_d = 1'b1;
                    rr_d    = rr_nxt;
                    cnt_d   = '0;
`ifdef UART_ARB_TAG_EN
                    tx_data_d = {4'hA, sel};
                    byte_d    = sel_byte;
                    state_d   = S_TAG_BUSY;
`else
                    tx_data_d = sel_byte;
                    state_d   = S_WAIT_BUSY;
`endif
                end
            end
            S_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = S_IDLE;
                end
            end
`ifdef UART_ARB_TAG_EN
            S_TAG_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = S_TAG_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_TAG_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = S_TAG_GAP;
                end
            end
            S_TAG_GAP: begin
                tx_data_d = byte_q;
                start_d   = 1'b1;
                cnt_d     = '0;
                state_d   = S_WAIT_BUSY;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rr_q      <= 4'd0;
            cnt_q     <= '0;
            tx_data_q <= 8'h00;
            grant_q   <= 4'd0;
            ack_q     <= '0;
            start_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            start_q   <= start_d;
            err_q     <= err_d;
        end
    end

`ifdef UART_ARB_TAG_EN
    // Data byte parked while its tag frame is on the line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_q <= 8'h00;
        end else begin
            byte_q <= byte_d;
        end
    end
`endif

    assign bus.tx_data     = tx_data_q;
    assign bus.tx_start    = start_q;
    assign bus.req_ack     = ack_q;
    assign bus.grant_id    = grant_q;
    assign bus.err_timeout = err_q;
    assign bus.arb_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grant table plus reset/tag sequences.
// Transmitter is modelled inline; tx_busy is driven on falling edges.
module tb_uart_tx_arbiter;

    localparam int NR = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(NR),
        .START_TIMEOUT(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] data;
        int          busy_len;
        logic [3:0]  grant;
        logic [7:0]  byte_e;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.tx_busy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_start(output bit ok, output int n);
        ok = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (bus.tx_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("start_seen", 32'd0, 32'd1);
    endtask

    task automatic run_frame(input int len, input logic [7:0] b);
        bit stable;
        @(negedge clk);
        chk("start_pulse_len", bus.tx_start, 1'b0);
        chk("ack_pulse_len", bus.req_ack, 4'b0000);
        bus.tx_busy = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (bus.tx_data !== b || bus.arb_busy !== 1'b1) stable = 1'b0;
        end
        chk("data_hold", stable, 1'b1);
        bus.tx_busy = 1'b0;
        @(negedge clk);
        chk("arb_idle", bus.arb_busy, 1'b0);
        chk("gap_no_start", bus.tx_start, 1'b0);
        chk("idle_data_hold", bus.tx_data, b);
    endtask

    initial begin
        bit ok;
        int n;
        bit early;

        reset = 1'b1;
        bus.req = '0;
        bus.req_data = '0;
        bus.tx_busy = 1'b0;

        tbl[0]  = '{1'b1, 4'b0010, 32'h0000_5500, 3, 4'd1, 8'h55};
        tbl[1]  = '{1'b1, 4'b1111, 32'h1312_1110, 2, 4'd0, 8'h10};
        tbl[2]  = '{1'b0, 4'b1111, 32'h1312_1110, 2, 4'd1, 8'h11};
        tbl[3]  = '{1'b0, 4'b1111, 32'h1312_1110, 2, 4'd2, 8'h12};
        tbl[4]  = '{1'b0, 4'b1111, 32'h1312_1110, 2, 4'd3, 8'h13};
        tbl[5]  = '{1'b0, 4'b1111, 32'h1312_1110, 2, 4'd0, 8'h10};
        tbl[6]  = '{1'b0, 4'b0100, 32'h1312_1110, 0, 4'd2, 8'h12};
        tbl[7]  = '{1'b0, 4'b0101, 32'h1312_1110, 2, 4'd0, 8'h10};
        tbl[8]  = '{1'b0, 4'b1000, 32'h1312_1110, 2, 4'd3, 8'h13};
        tbl[9]  = '{1'b0, 4'b1001, 32'h1312_1110, 2, 4'd0, 8'h10};
        tbl[10] = '{1'b0, 4'b1001, 32'h1312_1110, 2, 4'd3, 8'h13};

        @(negedge clk);
        chk("rst_tx_start", bus.tx_start, 1'b0);
        chk("rst_tx_data", bus.tx_data, 8'h00);
        chk("rst_req_ack", bus.req_ack, 4'b0000);
        chk("rst_grant", bus.grant_id, 4'd0);
        chk("rst_err", bus.err_timeout, 1'b0);
        chk("rst_arb_busy", bus.arb_busy, 1'b0);

`ifndef UART_ARB_TAG_EN
        for (int v = 0; v < 11; v++) begin
            if (tbl[v].rst) begin
                bus.req = '0;
                apply_reset();
            end
            bus.req = tbl[v].req;
            bus.req_data = tbl[v].data;
            wait_start(ok, n);
            chk($sformatf("v%0d_grant", v), bus.grant_id, tbl[v].grant);
            chk($sformatf("v%0d_ack", v), bus.req_ack,
                4'(1) << tbl[v].grant);
            chk($sformatf("v%0d_data", v), bus.tx_data, tbl[v].byte_e);
            if (tbl[v].busy_len == 0) begin
                bus.req = '0;
                early = 1'b0;
                for (int i = 1; i < 16; i++) begin
                    @(negedge clk);
                    if (bus.err_timeout !== 1'b0 || bus.arb_busy !== 1'b1)
                        early = 1'b1;
                end
                chk($sformatf("v%0d_no_early_err", v), early, 1'b0);
                @(negedge clk);
                chk($sformatf("v%0d_err_pulse", v), bus.err_timeout, 1'b1);
                chk($sformatf("v%0d_err_idle", v), bus.arb_busy, 1'b0);
                @(negedge clk);
                chk($sformatf("v%0d_err_one_cycle", v), bus.err_timeout, 1'b0);
            end else begin
                run_frame(tbl[v].busy_len, tbl[v].byte_e);
            end
        end

        bus.req = '0;
        apply_reset();
        bus.req = 4'b0100;
        bus.req_data = 32'h00A5_0000;
        wait_start(ok, n);
        chk("mid_grant", bus.grant_id, 4'd2);
        chk("mid_data", bus.tx_data, 8'hA5);
        @(negedge clk);
        bus.tx_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.req = 4'b1100;
        @(negedge clk);
        chk("mid_ignored_req", bus.tx_start, 1'b0);
        chk("mid_busy", bus.arb_busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_data", bus.tx_data, 8'h00);
        chk("mid_rst_start", bus.tx_start, 1'b0);
        chk("mid_rst_ack", bus.req_ack, 4'b0000);
        chk("mid_rst_grant", bus.grant_id, 4'd0);
        chk("mid_rst_err", bus.err_timeout, 1'b0);
        chk("mid_rst_arb_busy", bus.arb_busy, 1'b0);
        @(negedge clk);
        bus.tx_busy = 1'b0;
        reset = 1'b0;
        wait_start(ok, n);
        chk("post_rst_latency", n, 1);
        chk("post_rst_grant", bus.grant_id, 4'd2);
        chk("post_rst_ack", bus.req_ack, 4'b0100);
        chk("post_rst_data", bus.tx_data, 8'hA5);
        bus.req = '0;
        run_frame(2, 8'hA5);
`else
        apply_reset();
        bus.req = 4'b0100;
        bus.req_data = 32'h003C_0000;
        wait_start(ok, n);
        chk("tag_data", bus.tx_data, 8'hA2);
        chk("tag_grant", bus.grant_id, 4'd2);
        chk("tag_ack", bus.req_ack, 4'b0100);
        @(negedge clk);
        chk("tag_start_len", bus.tx_start, 1'b0);
        chk("tag_ack_len", bus.req_ack, 4'b0000);
        bus.req = '0;
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("tag_hold", bus.tx_data, 8'hA2);
        bus.tx_busy = 1'b0;
        @(negedge clk);
        chk("tag_gap_start", bus.tx_start, 1'b0);
        chk("tag_gap_busy", bus.arb_busy, 1'b1);
        wait_start(ok, n);
        chk("tag_byte_latency", n, 1);
        chk("tag_byte_data", bus.tx_data, 8'h3C);
        chk("tag_byte_no_ack", bus.req_ack, 4'b0000);
        run_frame(3, 8'h3C);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART transmitter between NUM_REQ byte producers.
- Accepts one byte per request.
- Issues a one-cycle start pulse and holds the transmitter data bus stable until the transmitter finishes the frame.
- Sits between the producers and the transmitter, replacing a direct debounced-button start.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- START_TIMEOUT, 16, max cycles to wait for tx_busy to rise after a start pulse.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; level, held until acked.
- req_data  input  8*NUM_REQ  byte for requester i on bits [8i+7:8i].
- req_ack  output  NUM_REQ  one-cycle pulse: byte of requester i latched.
- tx_data  output  8  byte to transmitter; stable from start pulse until frame done.
- tx_start  output  1  one-cycle start pulse to transmitter.
- tx_busy  input  1  transmitter busy; high from after start until stop bit ends.
- arb_busy  output  1  high whenever state != IDLE.
- grant_id  output  4  index of requester currently being served.
- err_timeout  output  1  one-cycle pulse when tx_busy fails to rise.

Behaviour:

Reset values:
- tx_start=0, tx_data=0, req_ack=0, grant_id=0, err_timeout=0, arb_busy=0.
- rr_ptr=0, timeout counter=0, state=IDLE.
- Asserting reset mid-frame returns everything to these values immediately; the in-flight byte is dropped; tx_start is never left high.

States: IDLE, WAIT_BUSY, WAIT_DONE.

IDLE:
- If any req bit is high at edge k, select the first requester i scanning from rr_ptr upward, wrapping modulo NUM_REQ.
- After edge k, for that one cycle: tx_data=req_data[i], grant_id=i, req_ack[i]=1, tx_start=1.
- Also after edge k: rr_ptr=(i+1) mod NUM_REQ, counter cleared, state=WAIT_BUSY.
- Latency from req sampled to tx_start is one cycle.

WAIT_BUSY:
- tx_start=0.
- If tx_busy=1, go to WAIT_DONE.
- Else increment counter. When counter reaches START_TIMEOUT-1 with tx_busy still 0: pulse err_timeout for one cycle and go to IDLE. rr_ptr is not rewound.

WAIT_DONE:
- Stay while tx_busy=1.
- When tx_busy=0, go to IDLE.
- The next start can occur no earlier than one cycle later, so there is a minimum one-cycle gap between frames.

Fairness and boundary conditions:
- Simultaneous requests: served in rr_ptr order, so no requester waits more than NUM_REQ-1 frames.
- A requester that keeps req high after ack is treated as a new request, arbitrated fairly.
- req changes while not IDLE are ignored until IDLE.
- tx_data and grant_id hold their last values in IDLE.
- rr_ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
Macro UART_ARB_TAG_EN.
- Defined:
  - Each grant sends two frames: first a tag byte {4'hA, grant_id}, then the data byte.
  - Data is latched and req_ack pulses at grant time, exactly as in the base design.
  - tx_start pulses for the tag first. After the tag's WAIT_DONE completes, one cycle later tx_data switches to the data byte and tx_start pulses again.
  - Extra states TAG_BUSY and TAG_DONE behave like WAIT_BUSY and WAIT_DONE, including timeout.
  - A timeout on the tag aborts the data byte.
- Undefined: single frame per grant, as specified above.

Test Plan:
1. Reset, then req=4'b0010 with byte 0x55 -> next cycle req_ack=0010, tx_start=1, tx_data=0x55, grant_id=1. tx_data holds 0x55 until model tx_busy falls. arb_busy then drops.
2. req=4'b1111 held, bytes 0x10/0x11/0x12/0x13, rr_ptr=0 -> grants in order 0,1,2,3,0. Each tx_start occurs at least 1 cycle after the previous tx_busy fall.
3. tx_busy tied 0, single request -> err_timeout pulses exactly 16 cycles after tx_start. FSM returns to IDLE and serves the next request normally.
4. Assert reset while in WAIT_DONE with tx_data=0xA5 -> all outputs 0 in the same cycle. After release, the pending req is regranted starting from rr_ptr=0.
5. Requester 3 granted, then req=4'b1001 -> requester 0 granted next (wrap), then requester 3.
6. With UART_ARB_TAG_EN, req=4'b0100 with byte 0x3C -> two start pulses: tx_data=0xA2, then tx_data=0x3C. req_ack pulses once.
